// File: rtl/memory_stage_pkg.sv
// -----------------------------------------------------------------------------
// memory_stage_pkg
//   Shared types for the memory stage: the control word and debug word that
//   travel down the pipeline, the access-size encoding, the memory-stage FSM
//   state, and a helper that classifies an access as misaligned.
// -----------------------------------------------------------------------------
package memory_stage_pkg;

  localparam int unsigned XLEN = 32;

  // Access size as carried in the control word. Encoding 2'd3 is not listed
  // and is handled as a word access wherever size is decoded.
  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } rvga_mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } memory_state_e;

  // mem_size is kept as raw bits so the illegal value 3 can be represented.
  typedef struct packed {
    logic       rd_w_v;
    logic       mem_r_v;
    logic       mem_w_v;
    logic [1:0] mem_size;
    logic       mem_unsigned;
  } rvga_cword_s;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } rvga_dword_s;

  // Halves need an even address, words (and the illegal size 3) need a
  // multiple of four; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage : memory_stage_pkg

// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if
//   Request/response bus between the memory stage and the data memory.
//   master (memory stage): dmem_req_v, dmem_w_v, dmem_addr, dmem_wdata,
//                          dmem_wmask out; dmem_req_ready, dmem_resp_v,
//                          dmem_rdata in.
//   slave  (data memory):  the reverse.
//   One response (dmem_resp_v) is returned per accepted request, for loads
//   and stores alike.
// -----------------------------------------------------------------------------
interface memory_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  dmem_req_v;
  logic                  dmem_req_ready;
  logic                  dmem_w_v;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W-1:0]     dmem_wdata;
  logic [DATA_W/8-1:0]   dmem_wmask;
  logic                  dmem_resp_v;
  logic [DATA_W-1:0]     dmem_rdata;

  modport master (
    output dmem_req_v, dmem_w_v, dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_req_ready, dmem_resp_v, dmem_rdata
  );

  modport slave (
    input  dmem_req_v, dmem_w_v, dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_req_ready, dmem_resp_v, dmem_rdata
  );

endinterface : memory_stage_if

// File: rtl/memory_stage_mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational byte-lane logic for a 32-bit data memory.
//   Stores: byte-enable mask and lane-replicated write data.
//   Loads:  byte/half extraction from the returned word, sign- or
//           zero-extended to 32 bits.
//   Ports:
//     size_i        access size (0 byte, 1 half, 2/3 word)
//     zero_ext_i    1 = zero-extend loads, 0 = sign-extend
//     addr_lo_i     byte offset within the word
//     store_data_i  rs2 value for stores
//     rdata_i       word returned by memory
//     wmask_o       byte enables
//     wdata_o       lane-replicated store data
//     load_data_o   extracted and extended load value
// -----------------------------------------------------------------------------
module mem_lane_align
  import memory_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]          size_i,
  input  logic                zero_ext_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [DATA_W-1:0]   store_data_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] wmask_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   load_data_o
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Replicating the data into every lane lets memory just apply the mask,
  // with no shifter on the write path.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    wmask_o = 4'b1111;
    wdata_o = store_data_i;
    case (size_i)
      MEM_B: begin
        wmask_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_H: begin
        wmask_o = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Halves are only ever extracted from an aligned offset, so addr_lo[1]
  // alone selects the lane pair.
  assign load_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign load_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o = rdata_i;
    case (size_i)
      MEM_B:   load_data_o = {{24{load_byte[7]  & ~zero_ext_i}}, load_byte};
      MEM_H:   load_data_o = {{16{load_half[15] & ~zero_ext_i}}, load_half};
      default: ;
    endcase
  end

endmodule : mem_lane_align

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//   Fourth pipeline stage. Non-memory instructions are registered straight
//   through to writeback. Loads and stores are captured into hold registers
//   and run a request/response handshake on the dmem bus while the upstream
//   stages are stalled; the load result (or 0 for stores) is then registered
//   out with the held rd/control/debug words. Misaligned accesses issue no
//   request: they flow through with rd_w_v cleared, result 0, and a
//   one-cycle memory_misaligned pulse.
//   Ports:
//     clk_i, rst_i          clock, synchronous active-high reset
//     execute_rd            destination register from execute
//     execute_result        ALU result / effective address
//     execute_store_data    rs2 value for stores
//     cword_i, dword_i      control and debug words from execute
//     memory_stall          upstream holds its outputs while high
//     memory_misaligned     one-cycle pulse on a misaligned access
//     dmem                  data-memory bus (master side)
//     memory_rd, memory_result, cword_o, dword_o   registered to writeback
// -----------------------------------------------------------------------------
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  // Only 32 is supported: the lane logic assumes four byte lanes.
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [4:0]          execute_rd,
  input  logic [DATA_W-1:0]   execute_result,
  input  logic [DATA_W-1:0]   execute_store_data,
  input  rvga_cword_s         cword_i,
  input  rvga_dword_s         dword_i,
  output logic                memory_stall,
  output logic                memory_misaligned,
  memory_stage_if.master      dmem,
  output logic [4:0]          memory_rd,
  output logic [DATA_W-1:0]   memory_result,
  output rvga_cword_s         cword_o,
  output rvga_dword_s         dword_o
);

  memory_state_e       state_q;

  // Hold registers for the instruction owning the memory transaction.
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   sdata_q;
  logic [4:0]          rd_q;
  rvga_cword_s         cword_q;
  rvga_dword_s         dword_q;

  // Registered outputs.
  logic [4:0]          memory_rd_q;
  logic [DATA_W-1:0]   memory_result_q;
  rvga_cword_s         cword_o_q;
  rvga_dword_s         dword_o_q;
  logic                misaligned_q;

  logic                mem_op;
  logic                misaligned;
  rvga_cword_s         cword_killed;
  logic [DATA_W-1:0]   load_data;

  assign mem_op     = cword_i.mem_r_v | cword_i.mem_w_v;
  assign misaligned = is_misaligned(cword_i.mem_size, execute_result[1:0]);

  // A misaligned access still reaches writeback but must not write rd.
  always_comb begin
    cword_killed        = cword_i;
    cword_killed.rd_w_v = 1'b0;
  end

  // Stall is combinational from the incoming control word so the upstream
  // stage holds in the very cycle a memory op is accepted, and releases in
  // the response cycle so the next instruction lands right behind it.
  assign memory_stall = ((state_q == IDLE) & mem_op & ~misaligned) |
                        (state_q == REQ) |
                        ((state_q == WAIT) & ~dmem.dmem_resp_v);

  // One lane aligner serves both directions: in REQ it builds the store
  // mask/data, in WAIT it extracts the load, always from the held access.
  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .size_i       (cword_q.mem_size),
    .zero_ext_i   (cword_q.mem_unsigned),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (dmem.dmem_rdata),
    .wmask_o      (dmem.dmem_wmask),
    .wdata_o      (dmem.dmem_wdata),
    .load_data_o  (load_data)
  );

  assign dmem.dmem_req_v = (state_q == REQ);
  assign dmem.dmem_w_v   = cword_q.mem_w_v;
  assign dmem.dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};

  // NOTE: state and all pipeline registers are written with non-blocking
  // assignments so every register samples pre-edge values, independent of
  // statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      sdata_q         <= '0;
      rd_q            <= '0;
      cword_q         <= '0;
      dword_q         <= '0;
      memory_rd_q     <= '0;
      memory_result_q <= '0;
      cword_o_q       <= '0;
      dword_o_q       <= '0;
      misaligned_q    <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!mem_op) begin
            memory_result_q <= execute_result;
            memory_rd_q     <= execute_rd;
            cword_o_q       <= cword_i;
            dword_o_q       <= dword_i;
          end else if (misaligned) begin
            misaligned_q    <= 1'b1;
            memory_result_q <= '0;
            memory_rd_q     <= execute_rd;
            cword_o_q       <= cword_killed;
            dword_o_q       <= dword_i;
          end else begin
            addr_q    <= execute_result[ADDR_W-1:0];
            sdata_q   <= execute_store_data;
            rd_q      <= execute_rd;
            cword_q   <= cword_i;
            dword_q   <= dword_i;
            // Writeback sees a bubble until the response comes back.
            cword_o_q <= '0;
            state_q   <= REQ;
          end
        end

        REQ: begin
          if (dmem.dmem_req_ready) state_q <= WAIT;
        end

        WAIT: begin
          // The upstream still presents the stalled instruction this cycle;
          // it is not re-accepted because the FSM only accepts from IDLE.
          if (dmem.dmem_resp_v) begin
            memory_result_q <= cword_q.mem_w_v ? '0 : load_data;
            memory_rd_q     <= rd_q;
            cword_o_q       <= cword_q;
            dword_o_q       <= dword_q;
            state_q         <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign memory_rd         = memory_rd_q;
  assign memory_result     = memory_result_q;
  assign cword_o           = cword_o_q;
  assign dword_o           = dword_o_q;
  assign memory_misaligned = misaligned_q;

endmodule : memory_stage

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//   Drives instructions into memory_stage as an upstream stage would (holding
//   each one until memory_stall is low at a clock edge), with a data-memory
//   model on the dmem bus. Expected writeback values and expected bus
//   requests are queued when an instruction is driven and compared when the
//   DUT produces them.
// -----------------------------------------------------------------------------
module tb_memory_stage;
  import memory_stage_pkg::*;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] sdata;
    rvga_cword_s cw;
    rvga_dword_s dw;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] exp_res;
    rvga_cword_s exp_cw;
    logic        exp_mis;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    int          exp_stalls;
    int          exp_reqs;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  execute_rd;
  logic [31:0] execute_result;
  logic [31:0] execute_store_data;
  rvga_cword_s cword_i;
  rvga_dword_s dword_i;
  logic        memory_stall;
  logic        memory_misaligned;
  logic [4:0]  memory_rd;
  logic [31:0] memory_result;
  rvga_cword_s cword_o;
  rvga_dword_s dword_o;

  memory_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

  memory_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .execute_rd         (execute_rd),
    .execute_result     (execute_result),
    .execute_store_data (execute_store_data),
    .cword_i            (cword_i),
    .dword_i            (dword_i),
    .memory_stall       (memory_stall),
    .memory_misaligned  (memory_misaligned),
    .dmem               (dmem),
    .memory_rd          (memory_rd),
    .memory_result      (memory_result),
    .cword_o            (cword_o),
    .dword_o            (dword_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   req_cycles = 0;
  bit   slave_en = 1'b1;
  txn_t exp_q[$];
  txn_t req_q[$];
  logic [31:0] pc = 32'h0000_1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic rvga_cword_s mk_cw(input logic rd_w, input logic r, input logic w,
                                        input logic [1:0] size, input logic uns);
    rvga_cword_s c;
    c.rd_w_v       = rd_w;
    c.mem_r_v      = r;
    c.mem_w_v      = w;
    c.mem_size     = size;
    c.mem_unsigned = uns;
    return c;
  endfunction

  // Data-memory model: holds ready low for the instruction's configured
  // number of cycles, checks the accepted request, answers one cycle later.
  initial begin : dmem_model
    txn_t        t;
    int          wait_cnt;
    bit          resp_pending;
    logic [31:0] resp_data;
    wait_cnt     = 0;
    resp_pending = 1'b0;
    resp_data    = '0;
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_resp_v    = 1'b0;
    dmem.dmem_rdata     = '0;
    forever begin
      @(negedge clk_i);
      if (slave_en) begin
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_resp_v    = 1'b0;
        if (resp_pending) begin
          dmem.dmem_resp_v = 1'b1;
          dmem.dmem_rdata  = resp_data;
          resp_pending     = 1'b0;
        end else if (dmem.dmem_req_v) begin
          req_cycles++;
          if (req_q.size() == 0) begin
            check("req_unexpected", 32'd1, 32'd0);
          end else if (wait_cnt < req_q[0].dly) begin
            wait_cnt++;
          end else begin
            t = req_q.pop_front();
            wait_cnt = 0;
            dmem.dmem_req_ready = 1'b1;
            check("req_addr", dmem.dmem_addr, {t.addr[31:2], 2'b00});
            check("req_w_v", {31'b0, dmem.dmem_w_v}, {31'b0, t.cw.mem_w_v});
            if (t.cw.mem_w_v) begin
              check("req_wmask", {28'b0, dmem.dmem_wmask}, {28'b0, t.exp_mask});
              check("req_wdata", dmem.dmem_wdata, t.exp_wdata);
            end
            resp_pending = 1'b1;
            resp_data    = t.rdata;
          end
        end
      end
    end
  end

  // Present one instruction, hold it until the stage takes it, then compare
  // the writeback registers, stall length and number of request cycles.
  task automatic do_txn(input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sdata,
                        input rvga_cword_s cw, input logic [31:0] rdata, input int dly,
                        input logic [31:0] exp_res, input logic exp_mis,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
    txn_t t, e;
    int   stalls = 0;
    int   guard  = 0;
    int   req0;
    logic s;
    bit   mem = cw.mem_r_v | cw.mem_w_v;
    t.rd = rd; t.addr = addr; t.sdata = sdata; t.cw = cw; t.rdata = rdata; t.dly = dly;
    t.dw.pc = pc; t.dw.insn = $urandom();
    pc = pc + 32'd4;
    t.exp_res = exp_res; t.exp_mis = exp_mis; t.exp_mask = exp_mask; t.exp_wdata = exp_wdata;
    t.exp_cw = cw;
    if (exp_mis) t.exp_cw.rd_w_v = 1'b0;
    // Accept cycle + (ready wait states + handshake cycle) stall; the
    // response cycle itself does not.
    t.exp_stalls = (mem && !exp_mis) ? dly + 2 : 0;
    t.exp_reqs   = (mem && !exp_mis) ? dly + 1 : 0;
    if (mem && !exp_mis) req_q.push_back(t);
    exp_q.push_back(t);

    execute_rd         = rd;
    execute_result     = addr;
    execute_store_data = sdata;
    cword_i            = cw;
    dword_i            = t.dw;
    req0 = req_cycles;
    forever begin
      @(negedge clk_i); #1;
      s = memory_stall;
      if (s) stalls++;
      @(posedge clk_i); #1;
      if (!s) break;
      guard++;
      if (guard > 64) begin
        check("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end

    e = exp_q.pop_front();
    check("result", memory_result, e.exp_res);
    check("rd", {27'b0, memory_rd}, {27'b0, e.rd});
    check("cword", {26'b0, cword_o}, {26'b0, e.exp_cw});
    check("dword_pc", dword_o.pc, e.dw.pc);
    check("dword_insn", dword_o.insn, e.dw.insn);
    check("misaligned", {31'b0, memory_misaligned}, {31'b0, e.exp_mis});
    check("stall_cycles", stalls, e.exp_stalls);
    check("req_cycles", req_cycles - req0, e.exp_reqs);
  endtask

  task automatic idle_inputs();
    execute_rd         = '0;
    execute_result     = '0;
    execute_store_data = '0;
    cword_i            = '0;
    dword_i            = '0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_result", memory_result, 32'h0);
    check("rst_rd", {27'b0, memory_rd}, 32'h0);
    check("rst_cword", {26'b0, cword_o}, 32'h0);
    check("rst_dword", dword_o.pc, 32'h0);
    check("rst_stall", {31'b0, memory_stall}, 32'h0);
    check("rst_req_v", {31'b0, dmem.dmem_req_v}, 32'h0);
    check("rst_misaligned", {31'b0, memory_misaligned}, 32'h0);
    rst_i = 1'b0;

    // ALU op pass-through.
    do_txn(5'd5, 32'h0000_1234, 32'h0, mk_cw(1, 0, 0, 2'd0, 0), 32'h0, 0,
           32'h0000_1234, 1'b0, 4'h0, 32'h0);
    // SW with ready held low two cycles.
    do_txn(5'd0, 32'h0000_0100, 32'hDEAD_BEEF, mk_cw(0, 0, 1, MEM_W, 0), 32'h0, 2,
           32'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    // LB / LBU from 0x103.
    do_txn(5'd7, 32'h0000_0103, 32'h0, mk_cw(1, 1, 0, MEM_B, 0), 32'h8012_3456, 0,
           32'hFFFF_FF80, 1'b0, 4'h0, 32'h0);
    do_txn(5'd8, 32'h0000_0103, 32'h0, mk_cw(1, 1, 0, MEM_B, 1), 32'h8012_3456, 1,
           32'h0000_0080, 1'b0, 4'h0, 32'h0);
    // SH / LH at 0x102.
    do_txn(5'd0, 32'h0000_0102, 32'h0000_ABCD, mk_cw(0, 0, 1, MEM_H, 0), 32'h0, 1,
           32'h0, 1'b0, 4'b1100, 32'hABCD_ABCD);
    do_txn(5'd9, 32'h0000_0102, 32'h0, mk_cw(1, 1, 0, MEM_H, 0), 32'h7FFF_0000, 0,
           32'h0000_7FFF, 1'b0, 4'h0, 32'h0);
    // Low half with the sign bit set, signed and unsigned.
    do_txn(5'd10, 32'h0000_0100, 32'h0, mk_cw(1, 1, 0, MEM_H, 0), 32'h1234_8001, 0,
           32'hFFFF_8001, 1'b0, 4'h0, 32'h0);
    do_txn(5'd11, 32'h0000_0100, 32'h0, mk_cw(1, 1, 0, MEM_H, 1), 32'h1234_8001, 0,
           32'h0000_8001, 1'b0, 4'h0, 32'h0);
    // SB to lane 1, byte 2 load.
    do_txn(5'd0, 32'h0000_0205, 32'h1234_56A5, mk_cw(0, 0, 1, MEM_B, 0), 32'h0, 0,
           32'h0, 1'b0, 4'b0010, 32'hA5A5_A5A5);
    do_txn(5'd12, 32'h0000_0206, 32'h0, mk_cw(1, 1, 0, MEM_B, 0), 32'h0042_0000, 0,
           32'h0000_0042, 1'b0, 4'h0, 32'h0);
    // LW, and the illegal size 3 behaving as a word.
    do_txn(5'd13, 32'h0000_0300, 32'h0, mk_cw(1, 1, 0, MEM_W, 0), 32'hCAFE_F00D, 3,
           32'hCAFE_F00D, 1'b0, 4'h0, 32'h0);
    do_txn(5'd14, 32'h0000_0304, 32'h0, mk_cw(1, 1, 0, 2'd3, 0), 32'h1234_5678, 0,
           32'h1234_5678, 1'b0, 4'h0, 32'h0);
    do_txn(5'd15, 32'h0000_0302, 32'h0, mk_cw(1, 1, 0, 2'd3, 0), 32'h0, 0,
           32'h0, 1'b1, 4'h0, 32'h0);
    // Misaligned accesses: no request, result 0, rd write killed.
    do_txn(5'd16, 32'h0000_0101, 32'h0, mk_cw(1, 1, 0, MEM_W, 0), 32'h0, 0,
           32'h0, 1'b1, 4'h0, 32'h0);
    do_txn(5'd17, 32'h0000_0103, 32'h0, mk_cw(1, 1, 0, MEM_H, 0), 32'h0, 0,
           32'h0, 1'b1, 4'h0, 32'h0);
    do_txn(5'd0, 32'h0000_0102, 32'h5555_5555, mk_cw(0, 0, 1, MEM_W, 0), 32'h0, 0,
           32'h0, 1'b1, 4'h0, 32'h0);
    // ALU op right after a misaligned access: the pulse must be gone.
    do_txn(5'd18, 32'h0BAD_F00D, 32'h0, mk_cw(1, 0, 0, 2'd0, 0), 32'h0, 0,
           32'h0BAD_F00D, 1'b0, 4'h0, 32'h0);

    // Reset while waiting for a response; the late response is ignored.
    slave_en = 1'b0;
    @(negedge clk_i);
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_resp_v    = 1'b0;
    @(posedge clk_i); #1;
    execute_rd     = 5'd19;
    execute_result = 32'h0000_0200;
    cword_i        = mk_cw(1, 1, 0, MEM_W, 0);
    dword_i        = '0;
    @(posedge clk_i); #1;
    check("rstw_req_v", {31'b0, dmem.dmem_req_v}, 32'h1);
    @(negedge clk_i);
    dmem.dmem_req_ready = 1'b1;
    @(posedge clk_i); #1;
    dmem.dmem_req_ready = 1'b0;
    check("rstw_wait_stall", {31'b0, memory_stall}, 32'h1);
    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rstw_stall", {31'b0, memory_stall}, 32'h0);
    check("rstw_result", memory_result, 32'h0);
    @(negedge clk_i);
    dmem.dmem_resp_v = 1'b1;
    dmem.dmem_rdata  = 32'hAAAA_5555;
    @(posedge clk_i); #1;
    dmem.dmem_resp_v = 1'b0;
    check("rstw_resp_result", memory_result, 32'h0);
    check("rstw_resp_rd", {27'b0, memory_rd}, 32'h0);
    check("rstw_resp_cword", {26'b0, cword_o}, 32'h0);
    check("rstw_resp_dword", dword_o.pc, 32'h0);
    check("rstw_resp_stall", {31'b0, memory_stall}, 32'h0);
    check("rstw_resp_req_v", {31'b0, dmem.dmem_req_v}, 32'h0);
    slave_en = 1'b1;

    // Stage recovers: random ALU ops interleaved with word loads.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      v = $urandom();
      do_txn(5'(i + 20), v, 32'h0, mk_cw(1, 0, 0, 2'd0, 0), 32'h0, 0,
             v, 1'b0, 4'h0, 32'h0);
      do_txn(5'(i + 1), {v[31:2], 2'b00}, 32'h0, mk_cw(1, 1, 0, MEM_W, 0), ~v, i % 3,
             ~v, 1'b0, 4'h0, 32'h0);
    end

    idle_inputs();
    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_memory_stage
